// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver: conditions the raw lines, validates 11-bit frames and
// folds E0/F0/E1 prefixes into single key events on the 11-bit ps2_key bus.
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [10:0]      ps2_key,
  output logic             key_strobe,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [2:0] E1_SKIP = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Input conditioning
  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic [FCW-1:0] filt_cnt;
  logic           clk_filt;
  logic           fall;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_cnt  <= '0;
      clk_filt  <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive differing samples: accept the new level.
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  wire data_bit = data_sync[1];

  // Frame FSM and key-event state
  state_t           state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [10:0]      key_q, key_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [2:0]       skip_q, skip_d;
  logic             reject;

  wire [7:0] rx_byte   = shift_q[7:0];
  wire       frame_ok  = (^shift_q[8:0]) && shift_q[9];

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tmo_d    = tmo_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    reject   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall && !data_bit) begin
          state_d  = RECV;
          bitcnt_d = '0;
          tmo_d    = '0;
        end
      end

      RECV: begin
        if (fall) begin
          // LSB-first: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
          shift_d = {data_bit, shift_q[9:1]};
          tmo_d   = '0;
          if (bitcnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          reject  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CHECK: begin
        state_d = IDLE;
        if (!frame_ok) begin
          reject = 1'b1;
        end else if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else if (rx_byte == BYTE_E1) begin
          // Pause sends E1 plus seven more bytes; swallow the lot.
          skip_d = E1_SKIP;
        end else if (rx_byte == BYTE_E0) begin
          ext_d = 1'b1;
        end else if (rx_byte == BYTE_F0) begin
          brk_d = 1'b1;
        end else begin
          key_d    = {~key_q[10], ~brk_q, ext_q, rx_byte};
          strobe_d = 1'b1;
          ext_d    = 1'b0;
          brk_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Any rejected frame (bad bits or timeout) also drops pending prefixes.
    if (reject) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tmo_q    <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tmo_q    <= tmo_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: drives PS/2 frames and compares key events and
// error counts against a byte-level reference model.
module tb_ps2_key_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int ERR_W          = 4;
  localparam int HALF           = 20;
  localparam int ERR_MAX        = 2**ERR_W - 1;

  logic             clk      = 1'b0;
  logic             reset_n  = 1'b0;
  logic             ps2_clk  = 1'b1;
  logic             ps2_data = 1'b1;
  logic [10:0]      ps2_key;
  logic             key_strobe;
  logic             frame_err;
  logic [ERR_W-1:0] err_count;

  ps2_key_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .ERR_W         (ERR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_strobe(key_strobe),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-level key decoder
  bit          m_toggle, m_ext, m_brk;
  int          m_skip, m_err_sat, m_err_total, m_strobes;
  logic [10:0] exp_q[$];

  function automatic void model_reset();
    m_toggle  = 1'b0;
    m_ext     = 1'b0;
    m_brk     = 1'b0;
    m_skip    = 0;
    m_err_sat = 0;
  endfunction

  function automatic void model_reject();
    m_err_total++;
    if (m_err_sat < ERR_MAX) m_err_sat++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      m_toggle = !m_toggle;
      exp_q.push_back({m_toggle, !m_brk, m_ext, b});
      m_strobes++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Monitor: every strobe must carry the next expected key; key must hold otherwise
  int          strobes_seen = 0;
  int          errs_seen    = 0;
  logic [10:0] prev_key     = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_key = '0;
    end else begin
      if (key_strobe) begin
        strobes_seen++;
        if (exp_q.size() == 0) check("unexpected_strobe", 32'(exp_q.size()), 32'd1);
        else check("ps2_key", 32'(ps2_key), 32'(exp_q.pop_front()));
      end else if (ps2_key !== prev_key) begin
        check("key_hold", 32'(ps2_key), 32'(prev_key));
      end
      if (frame_err) errs_seen++;
      prev_key = ps2_key;
    end
  end

  // Stimulus helpers
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    if (bad_par || bad_stop) model_reject();
    else model_byte(b);
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err_sat));
    check({tag, "_err_pulses"}, 32'(errs_seen), 32'(m_err_total));
    check({tag, "_strobes"}, 32'(strobes_seen), 32'(m_strobes));
  endtask

  logic [7:0] e1_seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};

  initial begin
    model_reset();
    m_err_total = 0;
    m_strobes   = 0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_key", 32'(ps2_key), 32'h000);
    check("rst_strobe", 32'(key_strobe), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain make, then break
    send_frame(8'h1C, 0, 0);
    check("make_1c", 32'(ps2_key), 32'h61C);
    check_status("make");
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check("break_1c", 32'(ps2_key), 32'h01C);
    check_status("break");

    // Extended release, prefixes clear afterwards
    do_reset();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("ext_break_75", 32'(ps2_key), 32'h575);
    send_frame(8'h1C, 0, 0);
    check("after_ext_1c", 32'(ps2_key), 32'h21C);
    check_status("ext");

    // Parity error, then recovery
    send_frame(8'h1C, 1, 0);
    check("parity_err_count", 32'(err_count), 32'd1);
    send_frame(8'h1C, 0, 0);
    check("after_parity_1c", 32'(ps2_key), 32'h61C);
    check_status("parity");

    // Prefix followed by a bad-stop frame loses the prefix
    send_frame(8'hE0, 0, 0);
    send_frame(8'h33, 0, 1);
    send_frame(8'h1C, 0, 0);
    check("prefix_cleared_1c", 32'(ps2_key), 32'h21C);
    check_status("stop");

    // Timeout mid-frame
    model_reject();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT_CYCLES + 200) @(negedge clk);
    check_status("timeout");
    send_frame(8'h29, 0, 0);
    check("after_timeout_29", 32'(ps2_key), 32'h629);
    check_status("timeout_rec");

    // Pause sequence swallowed
    do_reset();
    foreach (e1_seq[i]) send_frame(e1_seq[i], 0, 0);
    check("pause_then_1c", 32'(ps2_key), 32'h61C);
    check_status("pause");

    // Short ps2_clk glitches with data low must not start a frame
    ps2_data = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check_status("glitch");
    send_frame(8'h1C, 0, 0);
    check("after_glitch_1c", 32'(ps2_key), 32'h21C);

    // Reset mid-frame discards partial frame and prefix, no error
    send_frame(8'hE0, 0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    do_reset();
    check("midrst_err_count", 32'(err_count), 32'd0);
    send_frame(8'h1C, 0, 0);
    check("after_midrst_1c", 32'(ps2_key), 32'h61C);
    check_status("midrst");

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [7:0]  b;
      bit          bp, bs;
      r  = $urandom_range(0, 11);
      b  = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : 8'($urandom);
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 15) == 0);
      send_frame(b, bp, bs);
      check_status("rand");
    end

    // Error counter saturation
    do_reset();
    for (int i = 0; i < ERR_MAX + 3; i++) send_frame(8'($urandom), 1, 0);
    check("sat_err_count", 32'(err_count), 32'(ERR_MAX));
    check_status("sat");

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
